// File: rtl/ucsbece154b_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage:
// NOP encoding, RV32 instruction field positions and the buffer entry type.
package ucsbece154b_fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OP_LSB   = 0;
    localparam int OP_MSB   = 6;
    localparam int RD_LSB   = 7;
    localparam int RD_MSB   = 11;
    localparam int F3_LSB   = 12;
    localparam int F3_MSB   = 14;
    localparam int RS1_LSB  = 15;
    localparam int RS1_MSB  = 19;
    localparam int RS2_LSB  = 20;
    localparam int RS2_MSB  = 24;
    localparam int F7B5_BIT = 30;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Force a redirect target onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ucsbece154b_fetch_buf.sv
// Small circular FIFO of {pc, instr} entries between the imem response
// channel and the IF/ID register. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module ucsbece154b_fetch_buf
    import ucsbece154b_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [PW-1:0] count_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    fetch_entry_t  mem_q [DEPTH];

    assign count_o = wr_q - rd_q;
    assign full_o  = (count_o == PW'(DEPTH));
    assign empty_o = (wr_q == rd_q);
    assign head_o  = mem_q[rd_q[PW-2:0]];

    // Pointer update; clear discards all entries on a redirect.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clear_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_q[PW-2:0]] <= push_entry_i;
    end

endmodule

// File: rtl/ucsbece154b_fetch.sv
// Instruction fetch stage plus IF/ID register. Requests are credit limited so
// outstanding plus buffered fetches never exceed DEPTH; responses come back in
// order and are either dropped (after a redirect), bypassed into D, or buffered.
module ucsbece154b_fetch
    import ucsbece154b_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        StallD_i,
    input  logic        FlushD_i,
    input  logic        PCSrcE_i,
    input  logic [31:0] PCTargetE_i,
    output logic [31:0] InstrD_o,
    output logic [31:0] PCD_o,
    output logic [31:0] PCPlus4D_o,
    output logic        ValidD_o,
    output logic [6:0]  op_o,
    output logic [2:0]  funct3_o,
    output logic        funct7b5_o,
    output logic [4:0]  Rs1D_o,
    output logic [4:0]  Rs2D_o,
    output logic [4:0]  RdD_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   pcd_q, pcd_d;
    logic [31:0]   pcp4_q, pcp4_d;
    logic          valid_q, valid_d;

    logic          req_fire, rsp_keep, load_d, bypass, buf_push, buf_pop;
    logic [CW:0]   credits_used;
    fetch_entry_t  buf_head, rsp_entry;
    logic [CW-1:0] buf_count;
    logic          buf_full, buf_empty;

    assign credits_used     = {1'b0, inflight_q} + {1'b0, buf_count};
    assign imem_req_valid_o = reset & !PCSrcE_i & (credits_used < (CW+1)'(DEPTH));
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o & imem_req_ready_i;

    // A response survives only if nothing is pending to be dropped and no
    // redirect is happening this cycle.
    assign rsp_keep  = imem_rsp_valid_i & !PCSrcE_i & (drop_q == '0);
    // D takes new content only when neither squashed, held, nor redirected;
    // during a redirect all fetched words are wrong-path.
    assign load_d    = !FlushD_i & !StallD_i & !PCSrcE_i;
    assign bypass    = rsp_keep & buf_empty & load_d;
    assign buf_push  = rsp_keep & !bypass & !buf_full;
    assign buf_pop   = load_d & !buf_empty;
    assign rsp_entry = '{pc: rsp_pc_q, instr: imem_rsp_data_i};

    ucsbece154b_fetch_buf #(.DEPTH(DEPTH)) u_buf (
        .clk          (clk),
        .rst_ni       (reset),
        .clear_i      (PCSrcE_i),
        .push_i       (buf_push),
        .push_entry_i (rsp_entry),
        .pop_i        (buf_pop),
        .head_o       (buf_head),
        .count_o      (buf_count),
        .full_o       (buf_full),
        .empty_o      (buf_empty)
    );

    // Next-state for fetch PC, response tag PC, outstanding and drop counters.
    always_comb begin
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        if (PCSrcE_i) begin
            pc_d     = word_align(PCTargetE_i);
            rsp_pc_d = word_align(PCTargetE_i);
            drop_d   = inflight_d;
        end else begin
            if (req_fire) pc_d = pc_q + 32'd4;
            if (rsp_keep) rsp_pc_d = rsp_pc_q + 32'd4;
            if (imem_rsp_valid_i && (drop_q != '0)) drop_d = drop_q - 1'b1;
        end
    end

    // Next-state for the IF/ID register in flush > stall > buffer > bypass order.
    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (FlushD_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (StallD_i) begin
            valid_d = valid_q;
        end else if (buf_pop) begin
            instr_d = buf_head.instr;
            pcd_d   = buf_head.pc;
            pcp4_d  = buf_head.pc + 32'd4;
            valid_d = 1'b1;
        end else if (bypass) begin
            instr_d = rsp_entry.instr;
            pcd_d   = rsp_entry.pc;
            pcp4_d  = rsp_entry.pc + 32'd4;
            valid_d = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'd0;
            pcp4_q  <= 32'd4;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    assign InstrD_o   = instr_q;
    assign PCD_o      = pcd_q;
    assign PCPlus4D_o = pcp4_q;
    assign ValidD_o   = valid_q;
    assign op_o       = instr_q[OP_MSB:OP_LSB];
    assign RdD_o      = instr_q[RD_MSB:RD_LSB];
    assign funct3_o   = instr_q[F3_MSB:F3_LSB];
    assign Rs1D_o     = instr_q[RS1_MSB:RS1_LSB];
    assign Rs2D_o     = instr_q[RS2_MSB:RS2_LSB];
    assign funct7b5_o = instr_q[F7B5_BIT];

endmodule

// File: doc/ucsbece154b_fetch.md
Name: ucsbece154b_fetch

Overview:
Instruction fetch stage and IF/ID pipeline register for the pipelined RISC-V core. It sits on the consumer side of the controller's hazard outputs (StallD, FlushD, PCSrcE). It supplies the controller's decode inputs (op, funct3, funct7b5, Rs1D, Rs2D) from a variable-latency instruction memory. It uses a valid/ready request channel, an always-accepted response channel, and a small credit-limited instruction buffer.

Parameters:
RESET_PC, 32'h0000_0000, PC of first fetch after reset
DEPTH, 2, instruction-buffer entries; also the maximum outstanding plus buffered fetches (power of 2, ≥2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset)
imem_req_valid_o  out  1  fetch request valid
imem_req_ready_i  in  1  imem accepts request
imem_req_addr_o  out  32  word-aligned fetch address
imem_rsp_valid_i  in  1  response valid (in order, never back-pressured)
imem_rsp_data_i  in  32  instruction word
StallD_i  in  1  hold IF/ID register (load-use stall)
FlushD_i  in  1  squash IF/ID register
PCSrcE_i  in  1  redirect fetch
PCTargetE_i  in  32  redirect target; bits [1:0] ignored
InstrD_o  out  32  decode-stage instruction
PCD_o  out  32  decode-stage PC
PCPlus4D_o  out  32  PCD_o + 4
ValidD_o  out  1  InstrD_o is a real fetched instruction
op_o, funct3_o, funct7b5_o, Rs1D_o, Rs2D_o, RdD_o  out  7/3/1/5/5/5  combinational field slices of InstrD_o

Behaviour:
- Reset (reset=0, async):
  - PC = RESET_PC; rsp_pc = RESET_PC; buffer empty; inflight = 0; drop = 0.
  - InstrD_o = NOP (32'h0000_0013); PCD_o = 0; PCPlus4D_o = 4; ValidD_o = 0; imem_req_valid_o = 0.
- Request channel:
  - imem_req_valid_o = reset_n & !PCSrcE_i & (inflight + buf_count < DEPTH).
  - imem_req_addr_o = PC.
  - Handshake on valid & ready: PC <= PC + 4; inflight++.
  - Addr and valid are held stable while valid & !ready. The only exception: a request may be withdrawn in a cycle with PCSrcE_i = 1.
- Response channel:
  - Every imem_rsp_valid_i is accepted; inflight--.
  - If drop > 0: discard the word, drop--.
  - Otherwise the word is tagged with rsp_pc, then rsp_pc += 4. If the buffer is empty and D is loading this cycle, the word bypasses the buffer straight into IF/ID. Otherwise it is pushed into the buffer.
- IF/ID update, priority order:
  1. FlushD_i: InstrD <= NOP, ValidD <= 0, PCD unchanged.
  2. StallD_i: hold all.
  3. Buffer non-empty: pop head into D, ValidD <= 1.
  4. Bypass response available: load it, ValidD <= 1.
  5. Otherwise: NOP, ValidD <= 0.
  - PCPlus4D_o is registered alongside PCD_o.
- Redirect (PCSrcE_i = 1):
  - PC <= rsp_pc <= {PCTargetE_i[31:2], 2'b00}; buffer cleared.
  - drop <= inflight_next, i.e. every request still outstanding after this cycle. A response arriving in the redirect cycle is discarded.
  - No request handshake in that cycle. Flush overrides stall.
- Credit invariant: inflight + buf_count ≤ DEPTH at all times. Therefore push to a full buffer cannot occur, and simultaneous push+pop at full/empty is legal.
- Buffer: circular, wrap-around pointers of log2(DEPTH)+1 bits.
- Latency: with a 1-cycle imem and no stalls, the instruction at PC reaches D 2 cycles after request handshake, and one instruction is delivered per cycle.
- Reset asserted mid-transaction: all state clears. Responses to pre-reset requests must not occur; imem shares the reset.

Decomposition:
- ucsbece154b_defines.vh gets: NOP encoding, field bit positions (op [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7b5 [30]).
- Sub-module ucsbece154b_fetch_buf: DEPTH-entry {pc, instr} FIFO with push/pop/clear, count, full/empty.

Test Plan:
- Reset, then ready=1 and 1-cycle imem returning addr-as-data → D sees PC 0,4,8,12 on consecutive cycles; ValidD=1 from cycle 2; no NOP gaps.
- StallD_i=1 for 3 cycles at PCD=8 → PCD/InstrD held at 8; at most DEPTH=2 requests outstanding+buffered; PCD=12 the cycle after release.
- 3-cycle imem latency, redirect to 0x100 with 2 requests in flight → both late responses dropped; next ValidD instruction has PCD=0x100; no 0x8/0xC ever reaches D.
- Response and PCSrcE_i coincide, target 0x203 → response discarded; imem_req_addr_o=0x200 the next cycle; InstrD=NOP that cycle.
- FlushD_i and StallD_i both high → InstrD=0x00000013, ValidD=0.
- imem_req_ready_i low 5 cycles → addr stays 0x0 and valid stays 1; reset pulsed low mid-stall → imem_req_valid_o=0 immediately; PCD=0; restart from RESET_PC.
